// File: rtl/bw_io_dtl_cfg_ctl.sv
// bw_io_dtl_cfg_ctl: loads a DTL pad-config scan chain MSB first and checks the shifted-out readback
module bw_io_dtl_cfg_ctl #(
  parameter int CHAIN_LEN = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  input  logic                 cfg_vld,
  output logic                 cfg_rdy,
  output logic                 chain_se,
  output logic                 chain_si,
  input  logic                 chain_so,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rdbk_data,
  output logic                 rdbk_err
);
  localparam int CW = $clog2(CHAIN_LEN);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [CHAIN_LEN-1:0] sh_q, gold_q, gold_prev_q, rdbk_d;
  logic                 prev_vld_q;
  assign rdbk_d = {rdbk_data[CHAIN_LEN-2:0], chain_so};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      gold_q      <= '0;
      gold_prev_q <= '0;
      prev_vld_q  <= 1'b0;
      cfg_rdy     <= 1'b0;
      chain_se    <= 1'b0;
      chain_si    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdbk_data   <= '0;
      rdbk_err    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cfg_rdy <= 1'b1;
          if (cfg_vld && cfg_rdy) begin
            state_q     <= SHIFT;
            cnt_q       <= '0;
            cfg_rdy     <= 1'b0;
            chain_se    <= 1'b1;
            busy        <= 1'b1;
            chain_si    <= cfg_data[CHAIN_LEN-1];
            sh_q        <= cfg_data << 1;
            gold_q      <= cfg_data;
            gold_prev_q <= gold_q;
          end
        end
        SHIFT: begin
          rdbk_data <= rdbk_d;
          if (cnt_q == CW'(CHAIN_LEN - 1)) begin
            state_q  <= DONE;
            chain_se <= 1'b0;
            chain_si <= 1'b0;
            done     <= 1'b1;
            rdbk_err <= prev_vld_q && (rdbk_d != gold_prev_q);
          end else begin
            cnt_q    <= cnt_q + CW'(1);
            chain_si <= sh_q[CHAIN_LEN-1];
            sh_q     <= sh_q << 1;
          end
        end
        DONE: begin
          state_q    <= IDLE;
          cnt_q      <= '0;
          done       <= 1'b0;
          busy       <= 1'b0;
          rdbk_err   <= 1'b0;
          cfg_rdy    <= 1'b1;
          prev_vld_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bw_io_dtl_cfg_ctl.sv
// tb_bw_io_dtl_cfg_ctl: scan-chain model plus scoreboard for the DTL config loader
module tb_bw_io_dtl_cfg_ctl;
  localparam int L = 24;
  logic clk = 1'b0, reset;
  logic [L-1:0] cfg_data, rdbk_data, chain, poke_val;
  logic cfg_vld, cfg_rdy, chain_se, chain_si, chain_so, busy, done, rdbk_err, poke_en;
  logic [1:0] data2, rdbk2, chain2;
  logic vld2, rdy2, se2, si2, busy2, done2, err2;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;

  bw_io_dtl_cfg_ctl #(.CHAIN_LEN(L)) dut (
    .clk(clk), .reset(reset), .cfg_data(cfg_data), .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy),
    .chain_se(chain_se), .chain_si(chain_si), .chain_so(chain_so), .busy(busy), .done(done),
    .rdbk_data(rdbk_data), .rdbk_err(rdbk_err));

  bw_io_dtl_cfg_ctl #(.CHAIN_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_data(data2), .cfg_vld(vld2), .cfg_rdy(rdy2),
    .chain_se(se2), .chain_si(si2), .chain_so(chain2[1]), .busy(busy2), .done(done2),
    .rdbk_data(rdbk2), .rdbk_err(err2));

  // external scan chains: position 0 nearest si, so shifts toward the MSB
  assign chain_so = chain[L-1];
  always @(posedge clk)
    if (reset) chain <= '0;
    else if (poke_en) chain <= poke_val;
    else if (chain_se) chain <= {chain[L-2:0], chain_si};
  always @(posedge clk)
    if (reset) chain2 <= '0;
    else if (se2) chain2 <= {chain2[0], si2};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  typedef struct {logic [L-1:0] data, rdbk; logic err;} exp_t;
  exp_t q[$];
  int run = -1, cyc = 0, last_acc = -1, acc_cnt = 0;
  bit bprev = 0, was_done = 0;
  logic [L-1:0] blast = '0;
  logic [2:0] rh = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    rh = {rh[1:0], reset};
    if (rh[1]) begin
      chk("rst_out", {cfg_rdy, chain_se, chain_si, busy, done, rdbk_err, rdbk_data}, '0);
      q.delete();
      bprev = 0;
      run = -1;
      was_done = 0;
    end else begin
      if (rh[2] && !rh[0]) chk("rdy_after_rst", cfg_rdy, 1);
      if (chain_se) begin
        if (q.size() == 0 || run < 0 || run >= L) chk("shift_unexp", 1, 0);
        else chk("si_bit", chain_si, q[0].data[L-1-run]);
        chk("shift_flags", {busy, cfg_rdy, done}, 3'b100);
        run++;
      end else chk("si_idle", chain_si, 0);
      if (done) begin
        if (q.size() == 0) chk("done_unexp", 1, 0);
        else begin
          e = q.pop_front();
          chk("shift_cnt", run, L);
          chk("sb_rdbk", rdbk_data, e.rdbk);
          chk("sb_err", rdbk_err, e.err);
          chk("chain_loaded", chain, e.data);
        end
        chk("done_flags", {busy, cfg_rdy, chain_se}, 3'b100);
        bprev = 1;
        run = -1;
        was_done = 1;
      end else begin
        chk("err_idle", rdbk_err, 0);
        if (was_done) chk("rdy_after_done", {cfg_rdy, busy}, 2'b10);
        was_done = 0;
      end
      if (cfg_vld && cfg_rdy && !reset) begin
        if (last_acc >= 0) chk("period", (cyc - last_acc) >= L + 2, 1);
        last_acc = cyc;
        acc_cnt++;
        e.data = cfg_data;
        e.rdbk = chain;
        e.err = bprev && (chain != blast);
        q.push_back(e);
        blast = cfg_data;
        run = 0;
      end
    end
  end

  task automatic poke(input logic [L-1:0] v);
    @(posedge clk); #2;
    poke_val = v;
    poke_en = 1;
    @(posedge clk); #2;
    poke_en = 0;
  endtask

  task automatic do_load(input logic [L-1:0] d, output logic [L-1:0] rb, output logic e);
    int n = 0;
    @(posedge clk); #2;
    while (!cfg_rdy && n < 100) begin @(posedge clk); #2; n++; end
    chk("rdy_wait", cfg_rdy, 1);
    cfg_vld = 1;
    cfg_data = d;
    @(posedge clk); #2;
    cfg_vld = 0;
    n = 0;
    while (!done && n < L + 10) begin @(posedge clk); #2; n++; end
    chk("done_wait", done, 1);
    rb = rdbk_data;
    e = rdbk_err;
  endtask

  typedef struct {bit init_en; logic [L-1:0] init, flip, data, exp_rdbk; logic exp_err;} vec_t;
  vec_t vt[8];

  initial begin
    logic [L-1:0] rb;
    logic e;
    int n, a0;
    vt[0] = '{1'b1, 24'h123456, 24'h000000, 24'hA5C30F, 24'h123456, 1'b0};
    vt[1] = '{1'b0, 24'h000000, 24'h000000, 24'hFFFFFF, 24'hA5C30F, 1'b0};
    vt[2] = '{1'b0, 24'h000000, 24'h000000, 24'h00FF00, 24'hFFFFFF, 1'b0};
    vt[3] = '{1'b0, 24'h000000, 24'h000000, 24'h0000AA, 24'h00FF00, 1'b0};
    vt[4] = '{1'b0, 24'h000000, 24'h000001, 24'h5A5A5A, 24'h0000AB, 1'b1};
    vt[5] = '{1'b0, 24'h000000, 24'h000000, 24'h000000, 24'h5A5A5A, 1'b0};
    vt[6] = '{1'b1, 24'hC0FFEE, 24'h000000, 24'h123456, 24'hC0FFEE, 1'b1};
    vt[7] = '{1'b0, 24'h000000, 24'h800000, 24'h654321, 24'h923456, 1'b1};
    reset = 1; cfg_vld = 1; cfg_data = '1; poke_en = 0; poke_val = '0; vld2 = 0; data2 = '0;
    repeat (4) @(posedge clk);
    #2;
    cfg_vld = 0;
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      if (vt[i].init_en) poke(vt[i].init);
      if (vt[i].flip != '0) poke(chain ^ vt[i].flip);
      do_load(vt[i].data, rb, e);
      chk($sformatf("vec%0d_rdbk", i), rb, vt[i].exp_rdbk);
      chk($sformatf("vec%0d_err", i), e, vt[i].exp_err);
    end
    // cfg_vld held high with data changing every cycle
    @(posedge clk); #2;
    a0 = acc_cnt;
    cfg_vld = 1;
    for (int i = 0; i < 3 * (L + 2); i++) begin
      cfg_data = L'($urandom);
      @(posedge clk); #2;
    end
    cfg_vld = 0;
    chk("cont_accepts", acc_cnt - a0, 3);
    n = 0;
    while (!cfg_rdy && n < 100) begin @(posedge clk); #2; n++; end
    // reset in the middle of a shift
    cfg_vld = 1;
    cfg_data = 24'h3C3C3C;
    @(posedge clk); #2;
    cfg_vld = 0;
    repeat (10) @(posedge clk);
    #2;
    chk("pre_abort_se", chain_se, 1);
    reset = 1;
    repeat (2) @(posedge clk);
    #2;
    reset = 0;
    for (int i = 0; i < L + 4; i++) begin
      @(posedge clk); #2;
      chk("abort_no_done", {done, chain_se}, 2'b00);
    end
    chk("abort_rdy", cfg_rdy, 1);
    do_load(24'h777777, rb, e);
    chk("abort_next_err", e, 0);
    // two-bit chain build
    @(posedge clk); #2;
    chk("l2_rdy", rdy2, 1);
    vld2 = 1;
    data2 = 2'b10;
    @(posedge clk); #2;
    vld2 = 0;
    chk("l2_c1", {se2, si2, busy2, rdy2, done2}, 5'b11100);
    @(posedge clk); #2;
    chk("l2_c2", {se2, si2, busy2, rdy2, done2}, 5'b10100);
    @(posedge clk); #2;
    chk("l2_done", {se2, si2, busy2, rdy2, done2, err2, rdbk2}, 8'b00101000);
    chk("l2_chain", chain2, 2'b10);
    @(posedge clk); #2;
    chk("l2_idle", {se2, busy2, rdy2, done2}, 4'b0010);
    repeat (3) begin
      @(posedge clk); #2;
      chk("l2_no_wrap", {se2, done2}, 2'b00);
    end
    vld2 = 1;
    data2 = 2'b01;
    @(posedge clk); #2;
    vld2 = 0;
    n = 0;
    while (!done2 && n < 10) begin @(posedge clk); #2; n++; end
    chk("l2_done2_lat", n, 2);
    chk("l2_rdbk2", {rdbk2, err2, done2}, 4'b1001);
    chk("l2_chain2", chain2, 2'b01);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bw_io_dtl_cfg_ctl.md
BW_IO_DTL_CFG_CTL -- requirements
Module: bw_io_dtl_cfg_ctl

Interface
REQ-001 Parameter CHAIN_LEN, default 24, SHALL set the scan-chain length in bits (8 DTL pad-config stages x 3 bits); legal range 2..256.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 cfg_data  input  CHAIN_LEN  SHALL carry the configuration word to load; bit k is destined for chain position k, where position 0 is nearest chain_si.
REQ-005 cfg_vld  input  1  SHALL indicate that cfg_data is valid.
REQ-006 cfg_rdy  output  1  SHALL indicate that the block can accept a word.
REQ-007 chain_se  output  1  SHALL drive the scan-enable of every chain flop.
REQ-008 chain_si  output  1  SHALL drive the scan input of chain position 0.
REQ-009 chain_so  input  1  SHALL carry the scan output of chain position CHAIN_LEN-1.
REQ-010 busy  output  1  SHALL be high while a load is in progress.
REQ-011 done  output  1  SHALL be a one-cycle pulse on load completion.
REQ-012 rdbk_data  output  CHAIN_LEN  SHALL hold the chain contents shifted out during the last load.
REQ-013 rdbk_err  output  1  SHALL flag a readback mismatch; qualified by done.

Function
REQ-014 The controller SHALL use three states: IDLE, SHIFT and DONE, with all outputs registered.
REQ-015 In IDLE, cfg_rdy SHALL be 1, chain_se 0 and busy 0.
REQ-016 An accept SHALL occur on an edge where cfg_vld=1 and cfg_rdy=1; at that edge the block SHALL latch cfg_data into a shift register and a golden register, and enter SHIFT.
REQ-017 For an accept at edge T, cycles T+1..T+CHAIN_LEN SHALL be in SHIFT with chain_se=1, busy=1 and cfg_rdy=0.
REQ-018 Exactly CHAIN_LEN shift cycles SHALL occur, with no gaps.
REQ-019 Shift order SHALL be MSB first: cycle T+1+j drives chain_si = cfg_data[CHAIN_LEN-1-j] for j=0..CHAIN_LEN-1, so that position k holds cfg_data[k] after the load.
REQ-020 Readback: on each SHIFT edge the block SHALL sample chain_so and shift rdbk <= {rdbk[CHAIN_LEN-2:0], chain_so}, giving rdbk_data[k] = the prior content of position k.
REQ-021 The bit counter SHALL be ceil(log2(CHAIN_LEN)) bits wide, run 0..CHAIN_LEN-1 and leave SHIFT at terminal count without wrapping.
REQ-022 Cycle T+CHAIN_LEN+1 SHALL be DONE: done=1, chain_se=0, busy=1, cfg_rdy=0, rdbk_data stable.
REQ-023 The state after DONE SHALL be IDLE, with cfg_rdy=1 at cycle T+CHAIN_LEN+2; back-to-back loads are therefore separated by at least one IDLE cycle.
REQ-024 rdbk_err SHALL be 1 in DONE iff prev_vld=1 and rdbk_data differs from the golden word of the previous load.
REQ-025 If prev_vld=0, rdbk_err SHALL be 0.
REQ-026 prev_vld SHALL be set at the end of DONE.
REQ-027 rdbk_err SHALL be 0 outside DONE.
REQ-028 In SHIFT and DONE, cfg_vld and cfg_data SHALL be ignored (no accept, no corruption).
REQ-029 rdbk_data SHALL hold its value outside SHIFT.
REQ-030 The golden register SHALL update only on accept.
REQ-031 chain_si SHALL be 0 whenever chain_se=0.

Reset
REQ-032 While reset=1, the state SHALL be IDLE and the counter 0.
REQ-033 While reset=1, the outputs SHALL be cfg_rdy=0, chain_se=0, chain_si=0, busy=0, done=0, rdbk_err=0 and rdbk_data=0.
REQ-034 While reset=1, prev_vld and the golden register SHALL be cleared.
REQ-035 cfg_rdy SHALL rise in the first cycle after reset deasserts.
REQ-036 Reset SHALL dominate cfg_vld on the same edge.
REQ-037 Reset during SHIFT or DONE SHALL abort the load: no done pulse, chain_se=0 on the next cycle, chain contents undefined, prev_vld=0.

Verification
REQ-038 Scenario 1: reset, then cfg_data=24'hA5C3_0F with cfg_vld for 1 cycle -> chain_se=1 for exactly 24 cycles; chain_si sequence = bits 23..0 of 0xA5C30F; done at T+25; cfg_rdy at T+26.
REQ-039 Scenario 2: chain model initialised to 24'h123456, then load 24'hFFFFFF -> rdbk_data=24'h123456 and rdbk_err=0 (prev_vld=0).
REQ-040 Scenario 3: load 24'h00FF00, then load 24'h0000AA -> second done shows rdbk_data=24'h00FF00 and rdbk_err=0; corrupting one chain model bit between the loads -> rdbk_err=1.
REQ-041 Scenario 4: cfg_vld held high continuously with changing data -> accepts only in IDLE; each load uses the data present at its accept edge; minimum period CHAIN_LEN+2 cycles.
REQ-042 Scenario 5: reset asserted at shift cycle 10 -> chain_se=0 next cycle, no done, cfg_rdy=1 after release; the following load gives rdbk_err=0.
REQ-043 Scenario 6: CHAIN_LEN=2 build -> 2 shift cycles, done at T+3, counter does not wrap.
